multicycle_control: RTL and testbench

Multi-cycle control FSM for the 64-bit LEGv8 datapath, and the issuing end of the `aluOP` interface. It decodes the 11-bit opcode field from the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback. Each cycle it drives `aluOP`, mux selects and write strobes. It samples the ALU `zero` flag to resolve CBZ, and stalls on a memory ready handshake.

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the LEGv8 multi-cycle control FSM.
// master = control unit (drives strobes/selects), slave = datapath side.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [10:0]      opcode;
    logic             zero;
    logic             memReady;
    logic [2:0]       aluOP;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic             pcWrite;
    logic             pcSrc;
    logic             irWrite;
    logic             iOrD;
    logic             memRead;
    logic             memWrite;
    logic             regWrite;
    logic             memToReg;
    logic             reg2Loc;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instRetired;

    modport master (
        input  opcode, zero, memReady,
        output aluOP, aluSrcA, aluSrcB, pcWrite, pcSrc, irWrite, iOrD,
               memRead, memWrite, regWrite, memToReg, reg2Loc, illegal,
               state, instRetired
    );

    modport slave (
        output opcode, zero, memReady,
        input  aluOP, aluSrcA, aluSrcB, pcWrite, pcSrc, irWrite, iOrD,
               memRead, memWrite, regWrite, memToReg, reg2Loc, illegal,
               state, instRetired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 64-bit LEGv8 datapath (fetch/decode/execute/mem/wb).
// Optional retired-instruction counter enabled by defining CTRL_PERF_COUNT_EN.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_MEM = 4'd5,
        S_MEM_RD   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    typedef enum logic [3:0] {
        I_ADD, I_SUB, I_AND, I_ORR, I_LDUR, I_STUR, I_CBZ, I_B, I_ILL
    } inst_e;

    state_e state, state_nxt;
    inst_e  inst;

    function automatic inst_e decode_op(input logic [10:0] op);
        inst_e r;
        case (op)
            11'b10001011000: r = I_ADD;
            11'b11001011000: r = I_SUB;
            11'b10001010000: r = I_AND;
            11'b10101010000: r = I_ORR;
            11'b11111000010: r = I_LDUR;
            11'b11111000000: r = I_STUR;
            default: begin
                if (op[10:3] == 8'b10110100)    r = I_CBZ;
                else if (op[10:5] == 6'b000101) r = I_B;
                else                            r = I_ILL;
            end
        endcase
        return r;
    endfunction

    function automatic logic [2:0] rtype_aluop(input inst_e i);
        logic [2:0] r;
        case (i)
            I_SUB:   r = 3'b001;
            I_AND:   r = 3'b010;
            I_ORR:   r = 3'b011;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    assign inst      = decode_op(bus.opcode);
    assign bus.state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Moore decode; only FETCH's load strobes and BRANCH's pcWrite look at inputs.
    always_comb begin
        state_nxt    = state;
        bus.aluOP    = 3'b000;
        bus.aluSrcA  = 1'b0;
        bus.aluSrcB  = 2'b00;
        bus.pcWrite  = 1'b0;
        bus.pcSrc    = 1'b0;
        bus.irWrite  = 1'b0;
        bus.iOrD     = 1'b0;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.regWrite = 1'b0;
        bus.memToReg = 1'b0;
        bus.reg2Loc  = 1'b0;
        bus.illegal  = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                bus.memRead = 1'b1;
                bus.aluSrcB = 2'b01;
                if (bus.memReady) begin
                    bus.irWrite = 1'b1;
                    bus.pcWrite = 1'b1;
                    state_nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.aluSrcB = 2'b11;
                bus.reg2Loc = (inst == I_STUR) || (inst == I_CBZ);
                case (inst)
                    I_ADD, I_SUB, I_AND, I_ORR: state_nxt = S_EXEC_R;
                    I_LDUR, I_STUR:             state_nxt = S_EXEC_MEM;
                    I_CBZ:                      state_nxt = S_BRANCH;
                    I_B:                        state_nxt = S_JUMP;
                    default:                    state_nxt = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                bus.aluSrcA = 1'b1;
                bus.aluOP   = rtype_aluop(inst);
                state_nxt   = S_WB_R;
            end
            S_WB_R: begin
                bus.regWrite = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_EXEC_MEM: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                bus.reg2Loc = (inst == I_STUR);
                state_nxt   = (inst == I_STUR) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                bus.memRead = 1'b1;
                bus.iOrD    = 1'b1;
                if (bus.memReady) state_nxt = S_WB_MEM;
            end
            S_WB_MEM: begin
                bus.regWrite = 1'b1;
                bus.memToReg = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MEM_WR: begin
                bus.memWrite = 1'b1;
                bus.iOrD     = 1'b1;
                bus.reg2Loc  = 1'b1;
                if (bus.memReady) state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                bus.aluSrcA = 1'b1;
                bus.reg2Loc = 1'b1;
                bus.aluOP   = 3'b100;
                bus.pcSrc   = 1'b1;
                bus.pcWrite = bus.zero;
                state_nxt   = S_FETCH;
            end
            S_JUMP: begin
                bus.pcWrite = 1'b1;
                bus.pcSrc   = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_TRAP: begin
                bus.illegal = 1'b1;
                state_nxt   = S_TRAP;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef CTRL_PERF_COUNT_EN
    logic [CNT_W-1:0] cnt;
    logic             retire;

    // Final cycle of every instruction; TRAP never retires.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEM_WR:                           retire = bus.memReady;
            default:                            retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (retire) cnt <= cnt + CNT_W'(1);
    end

    assign bus.instRetired = cnt;
`else
    assign bus.instRetired = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues hand-written per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;
    localparam int CNT_W = 4;

    // {state, aluOP, aluSrcA, aluSrcB, pcWrite, pcSrc, irWrite, iOrD,
    //  memRead, memWrite, regWrite, memToReg, reg2Loc, illegal}
    localparam logic [19:0] IDLE     = 20'b0000_000_0_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] FETCH_W  = 20'b0001_000_0_01_0_0_0_0_1_0_0_0_0_0;
    localparam logic [19:0] FETCH_GO = 20'b0001_000_0_01_1_0_1_0_1_0_0_0_0_0;
    localparam logic [19:0] DEC      = 20'b0010_000_0_11_0_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] DEC_R2L  = 20'b0010_000_0_11_0_0_0_0_0_0_0_0_1_0;
    localparam logic [19:0] EXR_ADD  = 20'b0011_000_1_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] EXR_SUB  = 20'b0011_001_1_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] EXR_AND  = 20'b0011_010_1_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] EXR_ORR  = 20'b0011_011_1_00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] WBR      = 20'b0100_000_0_00_0_0_0_0_0_0_1_0_0_0;
    localparam logic [19:0] EXM_LD   = 20'b0101_000_1_10_0_0_0_0_0_0_0_0_0_0;
    localparam logic [19:0] EXM_ST   = 20'b0101_000_1_10_0_0_0_0_0_0_0_0_1_0;
    localparam logic [19:0] MRD      = 20'b0110_000_0_00_0_0_0_1_1_0_0_0_0_0;
    localparam logic [19:0] WBM      = 20'b0111_000_0_00_0_0_0_0_0_0_1_1_0_0;
    localparam logic [19:0] MWR      = 20'b1000_000_0_00_0_0_0_1_0_1_0_0_1_0;
    localparam logic [19:0] BR_Z1    = 20'b1001_100_1_00_1_1_0_0_0_0_0_0_1_0;
    localparam logic [19:0] BR_Z0    = 20'b1001_100_1_00_0_1_0_0_0_0_0_0_1_0;
    localparam logic [19:0] JMP      = 20'b1010_000_0_00_1_1_0_0_0_0_0_0_0_0;
    localparam logic [19:0] TRAP     = 20'b1011_000_0_00_0_0_0_0_0_0_0_0_0_1;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010111111;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    typedef struct {
        logic [19:0]      v;
        logic [CNT_W-1:0] c;
        string            name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [19:0] act;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();
    multicycle_control #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign act = {bus.state, bus.aluOP, bus.aluSrcA, bus.aluSrcB, bus.pcWrite,
                  bus.pcSrc, bus.irWrite, bus.iOrD, bus.memRead, bus.memWrite,
                  bus.regWrite, bus.memToReg, bus.reg2Loc, bus.illegal};

    // Monitor: every cycle the DUT presents a control word; compare if one is expected.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (act === e.v && bus.instRetired === e.c) n_pass++;
            else $display("FAIL %s: got outs=%b cnt=%0d, want outs=%b cnt=%0d",
                          e.name, act, bus.instRetired, e.v, e.c);
        end
    end

    task automatic check_now(input string name, input logic [19:0] want);
        n_checks++;
        if (act === want && bus.instRetired === '0) n_pass++;
        else $display("FAIL %s: got outs=%b cnt=%0d, want outs=%b cnt=0",
                      name, act, bus.instRetired, want);
    endtask

    // Called at posedge+1: drive inputs, queue this cycle's expectation, advance one cycle.
    task automatic step(input logic [19:0] v, input logic mr, input logic z,
                        input logic ret, input string name);
        exp_t e;
        bus.memReady = mr;
        bus.zero     = z;
        e.v = v; e.c = exp_cnt; e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
`ifdef CTRL_PERF_COUNT_EN
        if (ret) exp_cnt = exp_cnt + 1'b1;
`else
        if (ret) exp_cnt = '0;
`endif
    endtask

    task automatic rtype(input logic [10:0] op, input logic [19:0] ex, input string name);
        bus.opcode = op;
        step(FETCH_GO, 1, 0, 0, {name, "_fetch"});
        step(DEC,      0, 1, 0, {name, "_decode"});
        step(ex,       0, 0, 0, {name, "_exec"});
        step(WBR,      0, 0, 1, {name, "_wb"});
    endtask

    initial begin
        bus.opcode = OP_ADD; bus.zero = 0; bus.memReady = 0;
        repeat (2) @(posedge clk);
        #1;
        step(IDLE, 1, 0, 0, "reset_idle");
        rst_n = 1'b1;
        step(IDLE, 1, 0, 0, "idle_after_reset");

        rtype(OP_ADD, EXR_ADD, "add");
        bus.opcode = OP_SUB;
        step(FETCH_W, 0, 0, 0, "sub_fetch_wait");
        rtype(OP_SUB, EXR_SUB, "sub");
        rtype(OP_AND, EXR_AND, "and");
        rtype(OP_ORR, EXR_ORR, "orr");

        bus.opcode = OP_LDUR;
        step(FETCH_GO, 1, 0, 0, "ldur_fetch");
        step(DEC,      1, 0, 0, "ldur_decode");
        step(EXM_LD,   0, 0, 0, "ldur_exec");
        for (int i = 0; i < 3; i++) step(MRD, 0, 0, 0, "ldur_memrd_wait");
        step(MRD,      1, 0, 0, "ldur_memrd_go");
        step(WBM,      0, 0, 1, "ldur_wb");

        bus.opcode = OP_STUR;
        step(FETCH_GO, 1, 0, 0, "stur_fetch");
        step(DEC_R2L,  1, 0, 0, "stur_decode");
        step(EXM_ST,   1, 0, 0, "stur_exec");
        step(MWR,      0, 0, 0, "stur_memwr_wait");
        step(MWR,      1, 0, 1, "stur_memwr_go");

        bus.opcode = OP_CBZ;
        step(FETCH_GO, 1, 0, 0, "cbz1_fetch");
        step(DEC_R2L,  1, 0, 0, "cbz1_decode");
        step(BR_Z1,    0, 1, 1, "cbz_taken");
        step(FETCH_GO, 1, 1, 0, "cbz0_fetch");
        step(DEC_R2L,  1, 1, 0, "cbz0_decode");
        step(BR_Z0,    1, 0, 1, "cbz_not_taken");

        bus.opcode = OP_B;
        for (int i = 0; i < 9; i++) begin
            step(FETCH_GO, 1, 0, 0, "b_fetch");
            step(DEC,      1, 0, 0, "b_decode");
            step(JMP,      0, 0, 1, "b_jump");
        end

        // Abort a store mid-MEM_WR with an asynchronous reset.
        bus.opcode = OP_STUR;
        step(FETCH_GO, 1, 0, 0, "stur2_fetch");
        step(DEC_R2L,  1, 0, 0, "stur2_decode");
        step(EXM_ST,   1, 0, 0, "stur2_exec");
        bus.memReady = 0;
        begin
            exp_t e;
            e.v = MWR; e.c = exp_cnt; e.name = "stur2_memwr";
            q.push_back(e);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_now("async_reset_memwr", IDLE);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = '0;
        step(IDLE, 1, 0, 0, "idle_after_abort");

        bus.opcode = OP_ILL;
        step(FETCH_GO, 1, 0, 0, "ill_fetch");
        step(DEC,      1, 0, 0, "ill_decode");
        for (int i = 0; i < 20; i++) step(TRAP, i[0], i[1], 0, "trap_hold");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_now("async_reset_trap", IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(IDLE, 1, 0, 0, "idle_after_trap");
        step(FETCH_W, 0, 0, 0, "fetch_after_trap");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
